// File: rtl/uart_arb_if.sv
// Bundle between the UART transmit arbiter, its byte requesters and the UART_tx
// core. master is the arbiter's view; slave is the requester and UART side.
interface uart_arb_if #(
    parameter int NUM_REQ = 4
) ();
    localparam int OW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   ack;
    logic [OW-1:0]        owner;
    logic                 busy;
    logic                 trmt;
    logic [7:0]           tx_data;
    logic                 tx_done;
    logic                 timeout_err;

    modport master (
        input  req, req_data, req_last, tx_done,
        output ack, owner, busy, trmt, tx_data, timeout_err
    );

    modport slave (
        output req, req_data, req_last, tx_done,
        input  ack, owner, busy, trmt, tx_data, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART_tx among NUM_REQ byte sources; a source
// can hold the line across a multi-byte frame so frames never interleave.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TX_TIMEOUT   = 65535,
    parameter int LOCK_TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       rst,
    uart_arb_if.master bus
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int SW = OW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_BLANK = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_LOCK  = 3'd4;

    localparam logic [15:0]   TX_TERM   = 16'(TX_TIMEOUT - 1);
    localparam logic [15:0]   LOCK_TERM = 16'(LOCK_TIMEOUT - 1);
    localparam logic [OW-1:0] OWNER_RST = OW'(NUM_REQ - 1);

    logic [2:0]         state_reg, state_next;
    logic [OW-1:0]      owner_reg, owner_next;
    logic               lock_reg, lock_next;
    logic [15:0]        cnt_reg, cnt_next;
    logic               timeout_err_reg, timeout_err_next;
    logic               trmt_reg;
    logic [NUM_REQ-1:0] ack_reg, ack_next;
    logic [7:0]         tx_data_reg;
    logic               busy_reg;
    logic               load_go;

    logic [NUM_REQ-1:0] hit;
    logic [OW-1:0]      cand [NUM_REQ];
    logic [7:0]         data_byte [NUM_REQ];
    logic               rr_any;
    logic [OW-1:0]      rr_winner;

    // Candidate gi is the requester gi+1 places after the current owner, so
    // the lowest-numbered hit is the round-robin winner.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rr
            logic [SW-1:0] sum;
            assign sum       = SW'(owner_reg) + SW'(gi + 1);
            assign cand[gi]  = OW'((sum >= SW'(NUM_REQ)) ? sum - SW'(NUM_REQ) : sum);
            assign hit[gi]   = bus.req[cand[gi]];
            assign data_byte[gi] = bus.req_data[8*gi+7:8*gi];
            assign ack_next[gi]  = load_go && (owner_next == OW'(gi));
        end
    endgenerate

    always_comb begin
        rr_any    = |hit;
        rr_winner = cand[0];
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                rr_winner = cand[k];
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        owner_next       = owner_reg;
        lock_next        = lock_reg;
        timeout_err_next = timeout_err_reg;
        case (state_reg)
            S_IDLE: begin
                if (rr_any) begin
                    state_next = S_LOAD;
                    owner_next = rr_winner;
                end
            end
            S_LOAD: begin
                state_next = S_BLANK;
                lock_next  = !bus.req_last[owner_reg];
            end
            S_BLANK: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // tx_done outranks a timeout landing in the same cycle
                if (bus.tx_done) begin
                    if (!lock_reg) begin
                        state_next = S_IDLE;
                    end else if (bus.req[owner_reg]) begin
                        state_next = S_LOAD;
                    end else begin
                        state_next = S_LOCK;
                    end
                end else if (cnt_reg == TX_TERM) begin
                    state_next       = S_IDLE;
                    lock_next        = 1'b0;
                    timeout_err_next = 1'b1;
                end
            end
            S_LOCK: begin
                if (bus.req[owner_reg]) begin
                    state_next = S_LOAD;
                end else if (cnt_reg == LOCK_TERM) begin
                    state_next = S_IDLE;
                    lock_next  = 1'b0;
                end
            end
            default: begin
                state_next = S_IDLE;
                lock_next  = 1'b0;
            end
        endcase

        load_go = (state_next == S_LOAD);

        if (state_next != state_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == 16'hFFFF) begin
            cnt_next = cnt_reg;
        end else begin
            cnt_next = cnt_reg + 16'd1;
        end
    end

    // tx_data is captured on entry to LOAD so it is valid alongside trmt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            owner_reg       <= OWNER_RST;
            lock_reg        <= 1'b0;
            cnt_reg         <= '0;
            timeout_err_reg <= 1'b0;
            trmt_reg        <= 1'b0;
            ack_reg         <= '0;
            tx_data_reg     <= 8'h00;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            owner_reg       <= owner_next;
            lock_reg        <= lock_next;
            cnt_reg         <= cnt_next;
            timeout_err_reg <= timeout_err_next;
            trmt_reg        <= load_go;
            ack_reg         <= ack_next;
            busy_reg        <= (state_next != S_IDLE);
            if (load_go) begin
                tx_data_reg <= data_byte[owner_next];
            end
        end
    end

    assign bus.ack         = ack_reg;
    assign bus.owner       = owner_reg;
    assign bus.busy        = busy_reg;
    assign bus.trmt        = trmt_reg;
    assign bus.tx_data     = tx_data_reg;
    assign bus.timeout_err = timeout_err_reg;
endmodule
